uart_rx_deserializer: RTL and testbench

Receive front end of the UART unit. It synchronizes the asynchronous `rx_line`, recovers 8N1 frames using 16x oversampling with a 3-sample majority vote, and emits one-cycle byte strobes into the RX FIFO, which the CPU drains via `cpu_read`/`rx_ready`. It also reports framing errors and FIFO overruns to the UART status register.

---
 rtl/uart_rx_deserializer.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_deserializer
//  Purpose  : UART receive front end. Synchronizes the asynchronous serial
//             line, recovers 8N1 frames with OVERSAMPLE-times oversampling
//             and a 3-sample majority vote, and emits one-cycle byte strobes
//             toward the RX FIFO. Reports framing errors and FIFO overruns.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous reset, active low (0 = reset)
//             rx_line    - asynchronous serial input, idle high
//             fifo_full  - RX FIFO full flag, sampled at the stop-bit vote
//             err_clear  - one-cycle pulse clearing the sticky overrun flag
//             rx_data    - last good byte, held until the next good frame
//             rx_valid   - one-cycle write strobe to the RX FIFO
//             frame_err  - one-cycle pulse on a bad stop bit
//             overrun    - sticky: a byte was dropped because FIFO was full
//             busy       - high whenever the receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    input  logic       fifo_full,
    input  logic       err_clear,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int c_DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_SC_W  = $clog2(OVERSAMPLE);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    // Vote samples sit at the bit centre: OVERSAMPLE/2-1, /2 and /2+1.
    localparam logic [c_SC_W-1:0]  c_SC_S0    = c_SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SC_W-1:0]  c_SC_S1    = c_SC_W'(OVERSAMPLE / 2);
    localparam logic [c_SC_W-1:0]  c_SC_S2    = c_SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [c_SC_W-1:0]  c_SC_LAST  = c_SC_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic                 w_tick;
    logic                 r_tick_q;
    logic [c_SC_W-1:0]    r_sc;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic                 w_vote;
    logic                 w_at_vote;
    logic                 w_at_end;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 w_shift_en;
    logic                 w_idx_clr;
    logic                 w_idx_inc;
    logic                 w_load;
    logic                 w_set_valid;
    logic                 w_set_ferr;
    logic                 w_set_ovr;

    assign w_rx_s = r_sync2;
    assign busy   = (r_state != S_IDLE);

    // Two-flop synchronizer, reset to the idle (high) line level so that a
    // reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_line;
            r_sync2 <= r_sync1;
        end
    end

    // Tick divider is held at zero while idle so the oversampling phase is
    // anchored to the detected start edge.
    assign w_tick = (r_state != S_IDLE) && (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_tick_q  <= 1'b0;
            r_sc      <= '0;
        end else begin
            r_tick_q <= w_tick;
            if (r_state == S_IDLE) begin
                r_div_cnt <= '0;
                r_sc      <= '0;
            end else begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    r_sc      <= r_sc + c_SC_W'(1);
                end else begin
                    r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                end
            end
        end
    end

    // Sample-point events fire in the cycle after the tick that moved the
    // sample counter onto the given value, so each fires once per bit.
    assign w_at_vote = r_tick_q && (r_sc == c_SC_S2);
    assign w_at_end  = r_tick_q && (r_sc == c_SC_LAST);
    assign w_vote    = (r_samp_a & r_samp_b) | (r_samp_a & w_rx_s) | (r_samp_b & w_rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_samp_a <= 1'b1;
            r_samp_b <= 1'b1;
        end else if (r_tick_q) begin
            if (r_sc == c_SC_S0) r_samp_a <= w_rx_s;
            if (r_sc == c_SC_S1) r_samp_b <= w_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_load      = 1'b0;
        w_set_valid = 1'b0;
        w_set_ferr  = 1'b0;
        w_set_ovr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                // A high vote at the start-bit centre means a glitch.
                if (w_at_vote && w_vote) begin
                    w_state_nxt = S_IDLE;
                end else if (w_at_end) begin
                    w_state_nxt = S_DATA;
                    w_idx_clr   = 1'b1;
                end
            end
            S_DATA: begin
                if (w_at_vote) w_shift_en = 1'b1;
                if (w_at_end) begin
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                    else                   w_idx_inc   = 1'b1;
                end
            end
            S_STOP: begin
                // Leaving at the stop-bit centre leaves half a bit of slack
                // to catch a back-to-back start edge.
                if (w_at_vote) begin
                    if (w_vote) begin
                        w_state_nxt = S_IDLE;
                        w_load      = 1'b1;
                        if (fifo_full) w_set_ovr   = 1'b1;
                        else           w_set_valid = 1'b1;
                    end else begin
                        w_state_nxt = S_BREAK;
                        w_set_ferr  = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // Stay here while the line is held low so a break condition
                // cannot retrigger reception.
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_idx_clr)      r_bit_idx <= 3'd0;
            else if (w_idx_inc) r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift_en)     r_shift[r_bit_idx] <= w_vote;
            if (w_load)         rx_data <= r_shift;
            rx_valid  <= w_set_valid;
            frame_err <= w_set_ferr;
            // A new overrun in the same cycle as a clear keeps the flag set.
            if (w_set_ovr)      overrun <= 1'b1;
            else if (err_clear) overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_rx_deserializer
//  Purpose  : Self-checking bench for uart_rx_deserializer. Drives 8N1
//             frames at 8680 ns per bit and compares received bytes, error
//             pulses and flags against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

    localparam int BIT_NS  = 8680;
    localparam int HALF_NS = 4340;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line;
    logic       fifo_full;
    logic       err_clear;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_deserializer #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (115200),
        .OVERSAMPLE (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst_n),
        .rx_line   (rx_line),
        .fifo_full (fifo_full),
        .err_clear (err_clear),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed DUT activity, sampled on the falling edge.
    logic [7:0]  got_q[$];
    int unsigned got_t[$];
    int          ferr_cnt  = 0;
    bit          busy_seen = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            got_t.push_back(cyc);
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (busy)      busy_seen <= 1'b1;
    end

    // Frame-level reference model.
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_data = 8'h00;
    bit          exp_ovr  = 1'b0;
    int          exp_ferr = 0;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within 3 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Compare everything observed since the last call against the model.
    task automatic check_all(input string phase);
        int n;
        check($sformatf("%s.count", phase), 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.byte%0d", phase, i), 32'(got_q[i]), 32'(exp_q[i]));
        check($sformatf("%s.frame_err_count", phase), 32'(ferr_cnt), 32'(exp_ferr));
        check($sformatf("%s.rx_data", phase), 32'(rx_data), 32'(exp_data));
        check($sformatf("%s.overrun", phase), 32'(overrun), 32'(exp_ovr));
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string phase);
        check($sformatf("%s.rx_data", phase),   32'(rx_data),   32'h0);
        check($sformatf("%s.rx_valid", phase),  32'(rx_valid),  32'h0);
        check($sformatf("%s.frame_err", phase), 32'(frame_err), 32'h0);
        check($sformatf("%s.overrun", phase),   32'(overrun),   32'h0);
        check($sformatf("%s.busy", phase),      32'(busy),      32'h0);
    endtask

    // Serialize one 8N1 frame LSB first; the model is updated from the
    // frame rules: good stop -> byte delivered or dropped on a full FIFO,
    // bad stop -> framing error. The line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_line = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            #(BIT_NS);
        end
        if (stop) begin
            exp_data = b;
            if (fifo_full) exp_ovr = 1'b1;
            else           exp_q.push_back(b);
        end else begin
            exp_ferr++;
        end
        rx_line = stop;
        #(BIT_NS);
    endtask

    initial begin
        int unsigned t0;
        int unsigned lat;
        logic [7:0]  r1;
        logic [7:0]  r2;

        rst_n     = 1'b0;
        rx_line   = 1'b1;
        fifo_full = 1'b0;
        err_clear = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");

        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame with latency measurement from the falling edge.
        t0 = cyc;
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        if (got_t.size() > 0) begin
            lat = got_t[0] - t0;
            check("single.latency_4134_pm6", 32'((lat >= 4128) && (lat <= 4140)), 32'h1);
        end
        check_all("single");

        // Back-to-back frames with no idle gap, two of them random.
        r1 = 8'($urandom_range(255));
        r2 = 8'($urandom_range(255));
        @(negedge clk);
        send_frame(8'h5A, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(r1, 1'b1);
        send_frame(r2, 1'b1);
        repeat (10) @(negedge clk);
        check_all("b2b");

        // Short low glitch on an idle line.
        busy_seen = 1'b0;
        @(negedge clk);
        rx_line = 1'b0;
        #2000;
        rx_line = 1'b1;
        #(BIT_NS);
        check("glitch.busy_seen", 32'(busy_seen), 32'h1);
        check("glitch.busy_idle", 32'(busy), 32'h0);
        check_all("glitch");
        send_frame(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        check_all("after_glitch");

        // Bad stop bit followed by a line held low (three bit times total).
        send_frame(8'h33, 1'b0);
        #(2 * BIT_NS);
        check("break.busy_held", 32'(busy), 32'h1);
        check_all("ferr");
        rx_line = 1'b1;
        for (int k = 0; k < 50 && busy; k++) @(negedge clk);
        check("break.busy_released", 32'(busy), 32'h0);
        #(BIT_NS);
        send_frame(8'h01, 1'b1);
        repeat (10) @(negedge clk);
        check_all("after_break");

        // FIFO full: byte dropped, sticky overrun until cleared.
        fifo_full = 1'b1;
        send_frame(8'h77, 1'b1);
        fifo_full = 1'b0;
        repeat (100) @(negedge clk);
        check_all("overrun_set");
        err_clear = 1'b1;
        exp_ovr   = 1'b0;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        check_all("overrun_cleared");
        send_frame(8'h78, 1'b1);
        repeat (10) @(negedge clk);
        check_all("after_overrun");

        // Reset in the middle of frame 0xC3 (LSB first 1,1,0,0,0,0,1,1),
        // released while a high data bit is on the line.
        rx_line = 1'b0; #(BIT_NS);
        rx_line = 1'b1; #(BIT_NS);
        rx_line = 1'b1; #(BIT_NS);
        rx_line = 1'b0; #(HALF_NS);
        rst_n = 1'b0;
        exp_data = 8'h00;
        exp_ovr  = 1'b0;
        #(HALF_NS);
        check_reset_outputs("mid_reset");
        rx_line = 1'b0; #(3 * BIT_NS);
        rx_line = 1'b1; #(HALF_NS);
        rst_n = 1'b1;
        #(HALF_NS + 2 * BIT_NS);
        check_all("aborted_frame");
        send_frame(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        check_all("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
